// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT stream framer: error codes, framer states
// and the frame-length legality check.
package fft_stream_pkg;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_BADLEN = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_PAD  = 2'b10
  } fsm_state_t;

  // A legal frame length is a power of two inside [2^min_log2, 2^max_log2].
  function automatic logic is_legal_pts(input logic [31:0] pts,
                                        input int          min_log2,
                                        input int          max_log2);
    logic pow2_s;
    pow2_s = (pts != 32'd0) && ((pts & (pts - 32'd1)) == 32'd0);
    return pow2_s && (pts >= (32'd1 << min_log2)) && (pts <= (32'd1 << max_log2));
  endfunction

endpackage

// File: rtl/fft_st_out_reg.sv
// Single-entry valid/ready source register with full throughput; carries
// sample data plus packet framing, error code and point count.
module fft_st_out_reg
  import fft_stream_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter int               PTS_W   = 11,
  parameter logic [PTS_W-1:0] RST_PTS = {1'b1, {(PTS_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_real,
  input  logic [DATA_W-1:0] load_imag,
  input  logic              load_sop,
  input  logic              load_eop,
  input  logic [1:0]        load_err,
  input  logic [PTS_W-1:0]  load_pts,
  input  logic              source_ready,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  output logic [1:0]        source_error,
  output logic [DATA_W-1:0] source_real,
  output logic [DATA_W-1:0] source_imag,
  output logic [PTS_W-1:0]  source_pts
);

  // The slot may refill in the same cycle its current beat is taken.
  assign load_ready = !source_valid || source_ready;

  // Output slot: load on handshake, drain when taken, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= ERR_OK;
      source_real  <= {DATA_W{1'b0}};
      source_imag  <= {DATA_W{1'b0}};
      source_pts   <= RST_PTS;
    end else if (load_valid && load_ready) begin
      source_valid <= 1'b1;
      source_sop   <= load_sop;
      source_eop   <= load_eop;
      source_error <= load_err;
      source_real  <= load_real;
      source_imag  <= load_imag;
      source_pts   <= load_pts;
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_stream_framer.sv
// Avalon-ST front-end that cuts an unframed complex sample stream into
// FFT packets with sop/eop, point count, error code and zero padding.
module fft_stream_framer
  import fft_stream_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_LOG2 = 10,
  parameter int MIN_LOG2 = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  input  logic                in_flush,
  input  logic [MAX_LOG2:0]   fftpts_in,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sop,
  output logic                source_eop,
  output logic [1:0]          source_error,
  output logic [DATA_W-1:0]   source_real,
  output logic [DATA_W-1:0]   source_imag,
  output logic [MAX_LOG2:0]   fftpts_out,
  output logic                busy,
  output logic [CNT_W-1:0]    frames_done
);

  localparam int               PTS_W   = MAX_LOG2 + 1;
  localparam logic [PTS_W-1:0] PTS_MAX = {1'b1, {MAX_LOG2{1'b0}}};

  fsm_state_t          state_r, state_nxt_s;
  logic [MAX_LOG2-1:0] index_r, index_nxt_s;
  logic [MAX_LOG2-1:0] len_m1_r, len_m1_nxt_s;
  logic [1:0]          err_r, err_nxt_s;
  logic [PTS_W-1:0]    pts_r, pts_nxt_s;
  logic                run_r;
  logic [CNT_W-1:0]    frames_done_r;

  logic                legal_s;
  logic [PTS_W-1:0]    req_pts_s;
  logic [MAX_LOG2-1:0] req_len_m1_s;
  logic                in_ready_s, accept_s;
  logic                load_valid_s, load_ready_s;
  logic                beat_sop_s, beat_eop_s;
  logic [1:0]          beat_err_s;
  logic [PTS_W-1:0]    beat_pts_s;
  logic [DATA_W-1:0]   beat_real_s, beat_imag_s;

  // For a legal power of two the low bits minus one give N-1; 2^MAX wraps to all ones.
  assign legal_s      = is_legal_pts(32'(fftpts_in), MIN_LOG2, MAX_LOG2);
  assign req_pts_s    = legal_s ? fftpts_in : PTS_MAX;
  assign req_len_m1_s = legal_s ? (fftpts_in[MAX_LOG2-1:0] - MAX_LOG2'(1)) : {MAX_LOG2{1'b1}};

  // run_r keeps in_ready low until the first clock after reset release.
  assign in_ready_s = run_r && (state_r != ST_PAD) && load_ready_s;
  assign accept_s   = in_valid && in_ready_s;
  assign in_ready   = in_ready_s;

  // Framer next-state and the beat presented to the output slot.
  always_comb begin
    state_nxt_s  = state_r;
    index_nxt_s  = index_r;
    len_m1_nxt_s = len_m1_r;
    err_nxt_s    = err_r;
    pts_nxt_s    = pts_r;
    load_valid_s = 1'b0;
    beat_sop_s   = 1'b0;
    beat_eop_s   = 1'b0;
    beat_err_s   = err_r;
    beat_pts_s   = pts_r;
    beat_real_s  = in_real;
    beat_imag_s  = in_imag;
    case (state_r)
      ST_IDLE: begin
        beat_sop_s = 1'b1;
        beat_err_s = legal_s ? ERR_OK : ERR_BADLEN;
        beat_pts_s = req_pts_s;
        if (accept_s) begin
          load_valid_s = 1'b1;
          len_m1_nxt_s = req_len_m1_s;
          err_nxt_s    = beat_err_s;
          pts_nxt_s    = req_pts_s;
          index_nxt_s  = MAX_LOG2'(1);
          state_nxt_s  = in_flush ? ST_PAD : ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        beat_eop_s = (index_r == len_m1_r);
        if (accept_s) begin
          load_valid_s = 1'b1;
          if (beat_eop_s) begin
            index_nxt_s = {MAX_LOG2{1'b0}};
            state_nxt_s = ST_IDLE;
          end else if (in_flush) begin
            index_nxt_s = index_r + MAX_LOG2'(1);
            state_nxt_s = ST_PAD;
          end else begin
            index_nxt_s = index_r + MAX_LOG2'(1);
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_PAD: begin
        beat_real_s  = {DATA_W{1'b0}};
        beat_imag_s  = {DATA_W{1'b0}};
        beat_eop_s   = (index_r == len_m1_r);
        load_valid_s = 1'b1;
        if (load_ready_s) begin
          if (beat_eop_s) begin
            index_nxt_s = {MAX_LOG2{1'b0}};
            state_nxt_s = ST_IDLE;
          end else begin
            index_nxt_s = index_r + MAX_LOG2'(1);
          end
        end else begin
          state_nxt_s = ST_PAD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        index_nxt_s = {MAX_LOG2{1'b0}};
      end
    endcase
  end

  // Framer state, beat index and the per-frame length/error latched at sop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      index_r  <= {MAX_LOG2{1'b0}};
      len_m1_r <= {MAX_LOG2{1'b1}};
      err_r    <= ERR_OK;
      pts_r    <= PTS_MAX;
      run_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      index_r  <= index_nxt_s;
      len_m1_r <= len_m1_nxt_s;
      err_r    <= err_nxt_s;
      pts_r    <= pts_nxt_s;
      run_r    <= 1'b1;
    end
  end

  // Completed-packet counter, stepped by each eop beat taken downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_done_r <= {CNT_W{1'b0}};
    end else if (source_valid && source_ready && source_eop) begin
      frames_done_r <= frames_done_r + CNT_W'(1);
    end
  end

  assign frames_done = frames_done_r;
  assign busy        = (state_r != ST_IDLE) || (source_valid && !source_eop);

  fft_st_out_reg #(
    .DATA_W  (DATA_W),
    .PTS_W   (PTS_W),
    .RST_PTS (PTS_MAX)
  ) u_out_reg (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid_s),
    .load_ready   (load_ready_s),
    .load_real    (beat_real_s),
    .load_imag    (beat_imag_s),
    .load_sop     (beat_sop_s),
    .load_eop     (beat_eop_s),
    .load_err     (beat_err_s),
    .load_pts     (beat_pts_s),
    .source_ready (source_ready),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_pts   (fftpts_out)
  );

endmodule

// File: tb/tb_fft_stream_framer.sv
// Scoreboard bench for fft_stream_framer: expected beats are queued as
// stimulus is driven and compared as the DUT hands them downstream.
module tb_fft_stream_framer;

  localparam int DATA_W = 32;
  localparam int MAX_LOG2 = 10;
  localparam int MIN_LOG2 = 3;
  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] r;
    logic [31:0] i;
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [10:0] pts;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_real = 32'd0;
  logic [31:0]       in_imag = 32'd0;
  logic              in_flush = 1'b0;
  logic [10:0]       fftpts_in = 11'd8;
  logic              source_valid;
  logic              source_ready = 1'b1;
  logic              source_sop;
  logic              source_eop;
  logic [1:0]        source_error;
  logic [31:0]       source_real;
  logic [31:0]       source_imag;
  logic [10:0]       fftpts_out;
  logic              busy;
  logic [15:0]       frames_done;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int cyc = 0;
  int last_eop_cyc = 0;
  int sop_gap = 0;
  int stalls_seen = 0;
  bit rdy_mode = 1'b0;

  fft_stream_framer #(
    .DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2), .MIN_LOG2(MIN_LOG2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_flush(in_flush), .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
    .source_eop(source_eop), .source_error(source_error), .source_real(source_real),
    .source_imag(source_imag), .fftpts_out(fftpts_out), .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  function automatic int model_len(input int p);
    if (p >= 8 && p <= 1024 && (p & (p - 1)) == 0) return p;
    return 1024;
  endfunction

  function automatic logic [1:0] model_err(input int p);
    if (p >= 8 && p <= 1024 && (p & (p - 1)) == 0) return 2'b00;
    return 2'b01;
  endfunction

  task automatic push_beat(input logic [31:0] r, input logic [31:0] i, input logic sop,
                           input logic eop, input logic [1:0] err, input int pts);
    beat_t b;
    b.r = r; b.i = i; b.sop = sop; b.eop = eop; b.err = err; b.pts = 11'(pts);
    exp_q.push_back(b);
  endtask

  // Downstream ready: always 1, or the repeating pattern 1,0,0,1.
  initial begin
    int rc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        source_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
        rc++;
      end else begin
        source_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability and in_ready-under-stall.
  initial begin
    beat_t e;
    bit stall_prev = 1'b0;
    logic [31:0] snap_r, snap_i;
    logic snap_sop, snap_eop;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (source_valid !== 1'b1 || source_real !== snap_r || source_imag !== snap_i ||
              source_sop !== snap_sop || source_eop !== snap_eop) begin
            errors++;
            $display("FAIL hold_stable got v=%b r=%h i=%h expected v=1 r=%h i=%h",
                     source_valid, source_real, source_imag, snap_r, snap_i);
          end
        end
        if (source_valid === 1'b1 && source_ready === 1'b0) begin
          stalls_seen++;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_stall got %b expected 0", in_ready);
          end
          stall_prev = 1'b1;
          snap_r = source_real; snap_i = source_imag;
          snap_sop = source_sop; snap_eop = source_eop;
        end else begin
          stall_prev = 1'b0;
        end
        if (source_valid === 1'b1 && source_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got r=%h sop=%b eop=%b expected none",
                     source_real, source_sop, source_eop);
          end else begin
            e = exp_q.pop_front();
            if (source_real !== e.r || source_imag !== e.i || source_sop !== e.sop ||
                source_eop !== e.eop || source_error !== e.err || fftpts_out !== e.pts) begin
              errors++;
              $display("FAIL beat got r=%h i=%h sop=%b eop=%b err=%b pts=%0d expected r=%h i=%h sop=%b eop=%b err=%b pts=%0d",
                       source_real, source_imag, source_sop, source_eop, source_error, fftpts_out,
                       e.r, e.i, e.sop, e.eop, e.err, e.pts);
            end
          end
          if (source_sop === 1'b1) sop_gap = cyc - last_eop_cyc;
          if (source_eop === 1'b1) last_eop_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [31:0] r, input logic [31:0] i, input logic fl);
    bit ok = 1'b0;
    in_valid = 1'b1; in_real = r; in_imag = i; in_flush = fl;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1");
    end
  endtask

  task automatic run_frame(input int pts, input int nsamp, input bit flush_last,
                           input logic [31:0] base, input int alt_pts);
    int n;
    logic [1:0] e;
    n = model_len(pts);
    e = model_err(pts);
    fftpts_in = 11'(pts);
    for (int k = 0; k < nsamp; k++) begin
      push_beat(base + k, ~(base + k), k == 0, k == n - 1, e, n);
      send(base + k, ~(base + k), flush_last && (k == nsamp - 1));
      if (k == 0 && alt_pts >= 0) fftpts_in = 11'(alt_pts);
    end
    if (flush_last) begin
      for (int j = nsamp; j < n; j++) push_beat(32'd0, 32'd0, 1'b0, j == n - 1, e, n);
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
    exp_frames++;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && source_valid === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d expected 0", name, exp_q.size());
    end
    checks++;
    if (frames_done !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL %s_frames_done got %0d expected %0d", name, frames_done, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({source_valid, source_sop, source_eop, busy, in_ready, source_error} !== 7'b0 ||
        source_real !== 32'd0 || source_imag !== 32'd0 || frames_done !== 16'd0 ||
        fftpts_out !== 11'd1024) begin
      errors++;
      $display("FAIL reset_values got v=%b rdy=%b busy=%b pts=%0d fd=%0d expected 0 0 0 1024 0",
               source_valid, in_ready, busy, fftpts_out, frames_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_release got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clock got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    fftpts_in = 11'd8;
    checks++;
    if (source_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got %b expected 0", source_valid);
    end
    for (int k = 0; k < 8; k++) begin
      push_beat(32'(k + 1), 32'hF000_0000 + 32'(k), k == 0, k == 7, 2'b00, 8);
      send(32'(k + 1), 32'hF000_0000 + 32'(k), 1'b0);
      if (k == 0) begin
        checks++;
        if (source_valid !== 1'b1 || source_sop !== 1'b1 || source_real !== 32'd1) begin
          errors++;
          $display("FAIL latency got v=%b sop=%b r=%h expected 1 1 1", source_valid, source_sop, source_real);
        end
      end
    end
    in_valid = 1'b0;
    exp_frames++;
    wait_drain("basic");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_flush_pad();
    int low = 0;
    bit done = 1'b0;
    run_frame(16, 5, 1'b1, 32'h0000_0200, -1);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL pad_busy got %b expected 1", busy);
        end
      end
      if (in_ready === 1'b0) low++;
      else done = 1'b1;
    end
    checks++;
    if (low != 11) begin
      errors++;
      $display("FAIL pad_ready_low got %0d expected 11", low);
    end
    wait_drain("flush");
  endtask

  task automatic test_illegal_len();
    run_frame(12, 1024, 1'b0, 32'h0001_0000, -1);
    wait_drain("illegal");
  endtask

  task automatic test_backpressure();
    rdy_mode = 1'b1;
    run_frame(8, 8, 1'b0, 32'h0002_0000, -1);
    run_frame(8, 3, 1'b1, 32'h0003_0000, -1);
    wait_drain("stall");
    rdy_mode = 1'b0;
    checks++;
    if (stalls_seen == 0) begin
      errors++;
      $display("FAIL stall_seen got 0 expected >0");
    end
  endtask

  task automatic test_back_to_back();
    run_frame(8, 8, 1'b0, 32'h0004_0000, 64);
    run_frame(64, 64, 1'b0, 32'h0005_0000, -1);
    wait_drain("b2b");
    checks++;
    if (sop_gap != 1) begin
      errors++;
      $display("FAIL b2b_gap got %0d expected 1", sop_gap);
    end
  endtask

  task automatic test_reset_midframe();
    fftpts_in = 11'd32;
    for (int k = 0; k < 4; k++) begin
      push_beat(32'h0006_0000 + 32'(k), ~(32'h0006_0000 + 32'(k)), k == 0, 1'b0, 2'b00, 32);
      send(32'h0006_0000 + 32'(k), ~(32'h0006_0000 + 32'(k)), 1'b0);
    end
    in_valid = 1'b0;
    #7;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midframe_beats got pending=%0d expected 0", exp_q.size());
    end
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    checks++;
    if (source_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
        frames_done !== 16'd0 || fftpts_out !== 11'd1024) begin
      errors++;
      $display("FAIL async_reset got v=%b busy=%b rdy=%b fd=%0d pts=%0d expected 0 0 0 0 1024",
               source_valid, busy, in_ready, frames_done, fftpts_out);
    end
    exp_frames = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rerelease_ready got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    run_frame(8, 8, 1'b0, 32'h0007_0000, -1);
    wait_drain("after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_flush_pad();
    test_illegal_len();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
